mips_muldiv_unit: RTL

//  Parametrised multi-cycle multiply/divide unit with HI/LO result registers. It sits beside the

---
 rtl/mips_muldiv_pkg.sv | 21 ++
 rtl/mips_div_step.sv | 29 ++
 rtl/mips_muldiv_unit.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/mips_muldiv_pkg.sv
// Shared encodings for the MIPS multiply/divide unit: opcodes, FSM states and result constants.
package mips_muldiv_pkg;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } stateType;

    // LO value after a divide by zero; truncated to XLEN at the point of use.
    localparam logic [63:0] DIV_ZERO_LO = '1;

endpackage

// File: rtl/mips_div_step.sv
// One radix-2 restoring-division step: shift the next dividend bit into the partial remainder,
// subtract the divisor when it fits, and shift the resulting quotient bit into quo.
module mips_div_step #(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] remNext,
    output logic [XLEN-1:0] quoNext
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    // rem < divisor holds between steps, so a borrow shows up in diff's top bit.
    always_comb begin
        shifted = {rem, quo[XLEN-1]};
        diff    = shifted - {1'b0, divisor};
        if (diff[XLEN]) begin
            remNext = shifted[XLEN-1:0];
            quoNext = {quo[XLEN-2:0], 1'b0};
        end else begin
            remNext = diff[XLEN-1:0];
            quoNext = {quo[XLEN-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/mips_muldiv_unit.sv
// Multi-cycle MIPS multiply/divide unit with HI/LO result registers.
// Define FAST_MUL_EN for a single-cycle combinational multiply; otherwise multiply is shift-add.
module mips_muldiv_unit
    import mips_muldiv_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = $clog2(XLEN + 1)
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic            START,
    input  logic [2:0]      OP,
    input  logic [XLEN-1:0] SRC_A,
    input  logic [XLEN-1:0] SRC_B,
    input  logic            FLUSH,
    output logic            BUSY,
    output logic            DONE,
    output logic            DIV_BY_ZERO,
    output logic [XLEN-1:0] HI,
    output logic [XLEN-1:0] LO
);

    localparam int unsigned PW = 2 * XLEN;

    stateType         state;
    stateType         stateNext;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0]  opnd;
    logic [PW-1:0]    work;
    logic             isDiv;
    logic             resNeg;
    logic             remNeg;
    logic             divZero;

    logic             issue;
    logic             mtHi;
    logic             mtLo;
    logic             mulStep;
    logic             divStep;
    logic             commit;
    logic             lastStep;

    logic             opSigned;
    logic             opDiv;
    logic             aNeg;
    logic             bNeg;
    logic [XLEN-1:0]  aMag;
    logic [XLEN-1:0]  bMag;

    logic [PW-1:0]    mulNext;
    logic [PW-1:0]    prodFix;
    logic [XLEN-1:0]  remNext;
    logic [XLEN-1:0]  quoNext;
    logic [XLEN-1:0]  quoFix;
    logic [XLEN-1:0]  remFix;

    assign lastStep = (cnt == CNT_W'(XLEN - 1));

    // Issue-time operand conditioning: signed ops keep magnitudes plus the result signs.
    always_comb begin
        opSigned = (OP == OP_MULT) || (OP == OP_DIV);
        opDiv    = (OP == OP_DIV) || (OP == OP_DIVU);
        aNeg     = opSigned & SRC_A[XLEN-1];
        bNeg     = opSigned & SRC_B[XLEN-1];
        aMag     = aNeg ? -SRC_A : SRC_A;
        bMag     = bNeg ? -SRC_B : SRC_B;
    end

    // work holds {accumulator, multiplier} for MUL and {remainder, quotient} for DIV.
`ifdef FAST_MUL_EN
    assign mulNext = PW'(opnd) * PW'(work[XLEN-1:0]);
`else
    logic [XLEN:0] mulSum;
    assign mulSum  = {1'b0, work[PW-1:XLEN]} + (work[0] ? {1'b0, opnd} : (XLEN + 1)'(0));
    assign mulNext = {mulSum, work[XLEN-1:1]};
`endif

    mips_div_step #(
        .XLEN(XLEN)
    ) uDivStep (
        .rem    (work[PW-1:XLEN]),
        .quo    (work[XLEN-1:0]),
        .divisor(opnd),
        .remNext(remNext),
        .quoNext(quoNext)
    );

    assign prodFix = resNeg ? -work : work;
    assign quoFix  = resNeg ? -work[XLEN-1:0] : work[XLEN-1:0];
    assign remFix  = remNeg ? -work[PW-1:XLEN] : work[PW-1:XLEN];

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= S_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        if (FLUSH) begin
            stateNext = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (START && (OP == OP_MULT || OP == OP_MULTU)) begin
                        stateNext = S_MUL;
                    end else if (START && (OP == OP_DIV || OP == OP_DIVU)) begin
                        stateNext = S_DIV;
                    end
                end
`ifdef FAST_MUL_EN
                S_MUL:   stateNext = S_FIX;
`else
                S_MUL:   if (lastStep) stateNext = S_FIX;
`endif
                S_DIV:   if (lastStep) stateNext = S_FIX;
                S_FIX:   stateNext = S_IDLE;
                default: stateNext = S_IDLE;
            endcase
        end
    end

    // Datapath controls; FLUSH suppresses every update, including the FIX commit.
    always_comb begin
        issue   = 1'b0;
        mtHi    = 1'b0;
        mtLo    = 1'b0;
        mulStep = 1'b0;
        divStep = 1'b0;
        commit  = 1'b0;
        if (!FLUSH) begin
            case (state)
                S_IDLE: begin
                    issue = START && (OP <= OP_DIVU);
                    mtHi  = START && (OP == OP_MTHI);
                    mtLo  = START && (OP == OP_MTLO);
                end
                S_MUL:   mulStep = 1'b1;
                S_DIV:   divStep = 1'b1;
                S_FIX:   commit  = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt         <= '0;
            opnd        <= '0;
            work        <= '0;
            isDiv       <= 1'b0;
            resNeg      <= 1'b0;
            remNeg      <= 1'b0;
            divZero     <= 1'b0;
            BUSY        <= 1'b0;
            DONE        <= 1'b0;
            DIV_BY_ZERO <= 1'b0;
            HI          <= '0;
            LO          <= '0;
        end else begin
            BUSY        <= (stateNext != S_IDLE);
            DONE        <= commit;
            DIV_BY_ZERO <= commit & divZero;
            if (issue) begin
                cnt     <= '0;
                opnd    <= opDiv ? bMag : aMag;
                work    <= {XLEN'(0), (opDiv ? aMag : bMag)};
                isDiv   <= opDiv;
                resNeg  <= aNeg ^ bNeg;
                remNeg  <= aNeg;
                divZero <= opDiv && (SRC_B == '0);
            end
            if (mulStep) begin
                work <= mulNext;
                cnt  <= cnt + CNT_W'(1);
            end
            if (divStep) begin
                work <= {remNext, quoNext};
                cnt  <= cnt + CNT_W'(1);
            end
            if (mtHi) HI <= SRC_A;
            if (mtLo) LO <= SRC_A;
            // Divide by zero leaves the dividend in the remainder, so only LO needs overriding.
            if (commit) begin
                if (isDiv) begin
                    HI <= remFix;
                    LO <= divZero ? XLEN'(DIV_ZERO_LO) : quoFix;
                end else begin
                    HI <= prodFix[PW-1:XLEN];
                    LO <= prodFix[XLEN-1:0];
                end
            end
        end
    end

endmodule
